// File: rtl/cmd_queue_pkg.sv
// Shared types and constants for the button-to-UART command queue.
package cmd_queue_pkg;

    localparam int CMD_W = 8;
    localparam logic [CMD_W-1:0] CMD_RESET = 8'h00;

    typedef struct packed {
        logic [3:0] instrucao;
        logic [3:0] dado;
    } cmd_t;

    // Maps a raw button level to 1 = pressed, independent of wiring polarity.
    function automatic logic pressed_level(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Button front end: 2-FF synchronizer, debouncer and press pulse on the debounced rising edge.
// CMD_QUEUE_AUTOREPEAT_EN adds periodic repeat presses while the button stays held.
module debounce_sync
    import cmd_queue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int REPEAT_CYCLES     = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            sample;

`ifdef CMD_QUEUE_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
`else
    // No repeat hardware exists in this build; the period only has to be sane.
    if (REPEAT_CYCLES < 1) begin : g_repeat_period_invalid
    end
`endif

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        sample   = pressed_level(sync2_q, BUTTON_ACTIVE_LOW);
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sample != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_d = stable_d & ~stable_q;
`ifdef CMD_QUEUE_AUTOREPEAT_EN
        // Repeat period is measured from the initial press; a release clears it.
        rep_cnt_d = '0;
        if (stable_q && stable_d) begin
            if (rep_cnt_q == RP_W'(REPEAT_CYCLES - 1)) begin
                press_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RP_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= BUTTON_ACTIVE_LOW;
            sync2_q   <= BUTTON_ACTIVE_LOW;
            stable_q  <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
`ifdef CMD_QUEUE_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
`ifdef CMD_QUEUE_AUTOREPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cmd_queue.sv
// Turns debounced button presses into {instrucao, dado} bytes queued for the UART transmitter.
// Optional auto-repeat inside debounce_sync is enabled by CMD_QUEUE_AUTOREPEAT_EN.
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int DEPTH             = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1,
    parameter int REPEAT_CYCLES     = 25000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       botao,
    input  logic [3:0]                 dado,
    input  logic [3:0]                 instrucao,
    input  logic                       tx_ready,
    output logic                       tx_valid,
    output logic [CMD_W-1:0]           tx_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             press;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, pop, push;

    debounce_sync #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW),
        .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .raw  (botao),
        .press(press)
    );

    // Handshake: a byte transfers on every edge where tx_valid && tx_ready; tx_data
    // holds while tx_valid && !tx_ready, and tx_ready is ignored while tx_valid is low.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(DEPTH));
        pop        = !empty && tx_ready;
        push       = press && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (press & full & ~pop);
        if (push) begin
            mem_d[wr_ptr_q] = '{instrucao: instrucao, dado: dado};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= cmd_t'(CMD_RESET);
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: directed scenarios plus a randomized run against a queue model.
module tb_cmd_queue;

    localparam int DEPTH = 4;
    localparam int DEB   = 4;
    localparam int REP   = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             botao;
    logic [3:0]       dado;
    logic [3:0]       instrucao;
    logic             tx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_no      = 0;

    logic [7:0] exp_q[$];

    cmd_queue #(
        .DEPTH            (DEPTH),
        .DEBOUNCE_CYCLES  (DEB),
        .BUTTON_ACTIVE_LOW(1'b1),
        .REPEAT_CYCLES    (REP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .botao    (botao),
        .dado     (dado),
        .instrucao(instrucao),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .count    (count),
        .overflow (overflow)
    );

    // Clock / reset block
    always #5 clock = ~clock;
    always @(posedge clock) edge_no <= edge_no + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Driver tasks (inputs change on the falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic press_byte(input logic [7:0] b);
        @(negedge clock);
        {instrucao, dado} = b;
        botao = 1'b0;
        tick(8);
        botao = 1'b1;
        tick(8);
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1; botao = 1'b1; tx_ready = 1'b0; dado = 4'h0; instrucao = 4'h0;
        tick(2);
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        tests_run++;
        if (count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_press();
        int start;
        int lat;
        lat = -1;
        tx_ready = 1'b0;
        instrucao = 4'hA; dado = 4'h3;
        botao = 1'b0;
        start = edge_no;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_valid && lat < 0) lat = edge_no - start;
        end
        botao = 1'b1;
        tick(10);
        tests_run++;
        if (lat != 7) begin tests_failed++; $display("FAIL press_latency: got %0d edges expected 7", lat); end
        tests_run++;
        if (tx_data !== 8'hA3) begin tests_failed++; $display("FAIL press_data: got %h expected a3", tx_data); end
        tests_run++;
        if (count !== CNT_W'(1)) begin tests_failed++; $display("FAIL press_count: got %0d expected 1", count); end
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        tests_run++;
        if (count !== '0 || tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL press_drain: got count %0d valid %b expected 0 0", count, tx_valid);
        end
    endtask

    task automatic test_bounce();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            botao = 1'b0; tick(3);
            botao = 1'b1; tick(3);
        end
        tick(12);
        tests_run++;
        if (count !== '0 || tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bounce: got count %0d valid %b expected 0 0", count, tx_valid);
        end
    endtask

    task automatic test_queue_order();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) press_byte(bytes[i]);
        tests_run++;
        if (count !== CNT_W'(3)) begin tests_failed++; $display("FAIL order_count: got %0d expected 3", count); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== bytes[i]) begin
                tests_failed++;
                $display("FAIL order_pop%0d: got valid %b data %h expected 1 %h", i, tx_valid, tx_data, bytes[i]);
            end
            tick(1);
        end
        tx_ready = 1'b0;
        tests_run++;
        if (tx_valid !== 1'b0 || count !== '0) begin
            tests_failed++; $display("FAIL order_empty: got valid %b count %0d expected 0 0", tx_valid, count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6];
        logic [7:0] drain [4];
        int start;
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) press_byte(b[i]);
        tests_run++;
        if (count !== CNT_W'(DEPTH)) begin tests_failed++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL full_overflow: got %b expected 1", overflow); end
        tests_run++;
        if (tx_data !== b[0]) begin tests_failed++; $display("FAIL full_head: got %h expected %h", tx_data, b[0]); end
        // Sixth press lands on the same edge as a pop.
        @(negedge clock);
        {instrucao, dado} = b[5];
        botao = 1'b0;
        start = edge_no;
        tick(6);
        tx_ready = (edge_no == start + 6);
        tick(1);
        tx_ready = 1'b0;
        tick(1);
        botao = 1'b1;
        tick(8);
        tests_run++;
        if (count !== CNT_W'(DEPTH)) begin tests_failed++; $display("FAIL pushpop_full_count: got %0d expected %0d", count, DEPTH); end
        tests_run++;
        if (tx_data !== b[1]) begin tests_failed++; $display("FAIL pushpop_full_head: got %h expected %h", tx_data, b[1]); end
        drain[0] = b[1]; drain[1] = b[2]; drain[2] = b[3]; drain[3] = b[5];
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (tx_data !== drain[i]) begin
                tests_failed++; $display("FAIL overflow_drain%0d: got %h expected %h", i, tx_data, drain[i]);
            end
            tick(1);
        end
        tx_ready = 1'b0;
        tests_run++;
        if (count !== '0 || overflow !== 1'b1) begin
            tests_failed++; $display("FAIL overflow_sticky: got count %0d ovf %b expected 0 1", count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c;
        int seen;
        c = 8'($urandom);
        tx_ready = 1'b0;
        press_byte(8'h5A);
        press_byte(8'hC3);
        tests_run++;
        if (count !== CNT_W'(2)) begin tests_failed++; $display("FAIL rmid_pre_count: got %0d expected 2", count); end
        @(negedge clock);
        {instrucao, dado} = c;
        botao = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        tests_run++;
        if (tx_valid !== 1'b0 || count !== '0 || overflow !== 1'b0 || tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rmid_clear: got valid %b count %0d ovf %b data %h expected 0 0 0 00",
                     tx_valid, count, overflow, tx_data);
        end
        tick(1);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_valid) seen = 1;
        end
        botao = 1'b1;
        tick(10);
        tests_run++;
        if (seen != 1) begin tests_failed++; $display("FAIL rmid_press_seen: got %0d expected 1", seen); end
        tests_run++;
        if (count !== CNT_W'(1) || tx_data !== c) begin
            tests_failed++; $display("FAIL rmid_one_entry: got count %0d data %h expected 1 %h", count, tx_data, c);
        end
    endtask

    task automatic test_autorepeat();
        logic [7:0] b;
        int pops;
        int exp_pops;
`ifdef CMD_QUEUE_AUTOREPEAT_EN
        exp_pops = 4;
`else
        exp_pops = 1;
`endif
        tx_ready = 1'b1;
        tick(3);
        b = 8'($urandom);
        {instrucao, dado} = b;
        pops = 0;
        botao = 1'b0;
        for (int i = 0; i < 90; i++) begin
            if (i == 60) botao = 1'b1;
            if (tx_valid && tx_ready) begin
                pops++;
                tests_run++;
                if (tx_data !== b) begin tests_failed++; $display("FAIL repeat_data: got %h expected %h", tx_data, b); end
            end
            tick(1);
        end
        tx_ready = 1'b0;
        tests_run++;
        if (pops != exp_pops) begin tests_failed++; $display("FAIL repeat_count: got %0d bytes expected %0d", pops, exp_pops); end
    endtask

    task automatic test_random();
        int  btn_timer;
        bit  btn_low;
        int  push_edge;
        bit  exp_ovf;
        bit  pop;
        bit  push;
        bit  was_full;
        int  ready_pct;
        logic [7:0] pend;
        tx_ready = 1'b0;
        botao = 1'b1;
        tick(12);
        apply_reset();
        exp_q.delete();
        exp_ovf   = 1'b0;
        push_edge = -1;
        btn_low   = 1'b0;
        btn_timer = 5;
        pend      = 8'h00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            if (btn_timer == 0) begin
                if (btn_low) begin
                    botao = 1'b1;
                    btn_low = 1'b0;
                end else begin
                    pend = 8'($urandom);
                    {instrucao, dado} = pend;
                    botao = 1'b0;
                    btn_low = 1'b1;
                    push_edge = edge_no + 7;
                end
                btn_timer = $urandom_range(8, 12);
            end else begin
                btn_timer--;
            end
            ready_pct = (cyc < 200) ? 0 : (cyc < 400) ? 4 : 15;
            tx_ready = ($urandom_range(0, 15) < ready_pct);

            if (exp_q.size() > 0) begin
                tests_run++;
                if (tx_data !== exp_q[0]) begin
                    tests_failed++; $display("FAIL rand_head@%0d: got %h expected %h", edge_no, tx_data, exp_q[0]);
                end
            end
            pop      = (exp_q.size() > 0) && tx_ready;
            push     = (edge_no + 1 == push_edge);
            was_full = (exp_q.size() == DEPTH);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (was_full && !pop) exp_ovf = 1'b1;
                else exp_q.push_back(pend);
            end

            @(posedge clock);
            #1;
            tests_run++;
            if (count !== CNT_W'(exp_q.size()) || tx_valid !== (exp_q.size() != 0) || overflow !== exp_ovf) begin
                tests_failed++;
                $display("FAIL rand_state@%0d: got count %0d valid %b ovf %b expected %0d %b %b",
                         edge_no, count, tx_valid, overflow, exp_q.size(), exp_q.size() != 0, exp_ovf);
            end
        end
        tx_ready = 1'b0;
        botao = 1'b1;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_queue_order();
        test_overflow();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
